router_buffered: RTL

//  Parametrised 1-to-NUM_OUT packet router with per-output FIFO buffering and valid/ready flow control.

---
 rtl/router_pkg.sv | 35 +++
 rtl/router_fifo.sv | 74 +++++++
 rtl/router_buffered.sv | 87 ++++++++
 3 files changed

// File: rtl/router_pkg.sv
// Shared width helpers and channel-select decode for the buffered packet router.
// Contents:
//   MAX_OUT/MAX_AW   widest supported channel count and address width
//   addr_width()     address width for a channel count, never below 1
//   is_pow2()        FIFO depth legality check (power of 2, >= 2)
//   chan_sel()       per-channel push mask for a unicast or broadcast beat
package router_pkg;

    localparam int unsigned MAX_OUT = 16;
    localparam int unsigned MAX_AW  = 4;

    // Address width is clog2(n) but never narrower than one bit.
    function automatic int unsigned addr_width(input int unsigned n);
        return (n <= 1) ? 1 : 32'($clog2(n));
    endfunction

    function automatic bit is_pow2(input int unsigned n);
        return (n >= 2) && ((n & (n - 1)) == 0);
    endfunction

    // One-hot for a legal unicast, all channels for broadcast, zero for an illegal address.
    function automatic logic [MAX_OUT-1:0] chan_sel(input logic [MAX_AW-1:0] addr,
                                                    input logic              bcast,
                                                    input int unsigned       n);
        logic [MAX_OUT-1:0] sel;
        sel = '0;
        for (int unsigned i = 0; i < MAX_OUT; i++) begin
            if ((i < n) && (bcast || (32'(addr) == i))) begin
                sel[i] = 1'b1;
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/router_fifo.sv
// Synchronous FIFO for one router output channel.
// Ports:
//   clk, reset    rising-edge clock, synchronous active-high reset (empties the FIFO)
//   push_i/din_i  write request and payload; ignored when full, even if popping
//   pop_i         read request; ignored when empty
//   full_o/empty_o occupancy flags from the registered count
//   head_o        oldest entry (meaningless when empty)
module router_fifo
    import router_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push_i,
    input  logic                  pop_i,
    input  logic [DATA_WIDTH-1:0] din_i,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [DATA_WIDTH-1:0] head_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    if (!is_pow2(DEPTH)) begin : g_bad_depth
        $error("router_fifo: DEPTH must be a power of 2 and at least 2");
    end

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]         wptr_q, wptr_d;
    logic [PW-1:0]         rptr_q, rptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  do_push, do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign head_o  = mem_q[rptr_q];

    // Pointer and occupancy next-state; pointers wrap naturally at DEPTH.
    always_comb begin
        do_push = push_i & ~full_o;
        do_pop  = pop_i & ~empty_o;
        wptr_d  = do_push ? wptr_q + PW'(1) : wptr_q;
        rptr_d  = do_pop  ? rptr_q + PW'(1) : rptr_q;
        count_d = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: an empty FIFO never exposes its contents.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wptr_q] <= din_i;
        end
    end

endmodule

// File: rtl/router_buffered.sv
// 1-to-NUM_OUT packet router with a FIFO per output and valid/ready flow control.
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   din/din_valid/din_ready  upstream beat handshake; din_ready is combinational
//   addr, din_bcast       destination index, or broadcast to every channel
//   dout/dout_valid/dout_ready  per-channel downstream handshake, channel i on dout[i*DATA_WIDTH +: DATA_WIDTH]
//   addr_err              registered one-cycle pulse after an illegal-address beat is dropped
module router_buffered
    import router_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_OUT    = 4,
    parameter int unsigned DEPTH      = 4,
    localparam int unsigned AW        = addr_width(NUM_OUT)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [DATA_WIDTH-1:0]         din,
    input  logic                          din_valid,
    output logic                          din_ready,
    input  logic [AW-1:0]                 addr,
    input  logic                          din_bcast,
    output logic [NUM_OUT*DATA_WIDTH-1:0] dout,
    output logic [NUM_OUT-1:0]            dout_valid,
    input  logic [NUM_OUT-1:0]            dout_ready,
    output logic                          addr_err
);

    logic [NUM_OUT-1:0] sel, push, pop, full, empty;
    logic               addr_err_q, addr_err_d;

    // addr/din_bcast are only looked at when a beat is offered.
    always_comb begin
        sel        = '0;
        addr_err_d = 1'b0;
        if (din_valid) begin
            sel        = NUM_OUT'(chan_sel(MAX_AW'(addr), din_bcast, NUM_OUT));
            addr_err_d = ~din_bcast & (32'(addr) >= NUM_OUT);
        end
    end

    // Any selected full FIFO stalls the beat; broadcast is therefore all-or-nothing.
    // An illegal address selects nothing, so it is accepted and dropped.
    assign din_ready  = ~|(sel & full);
    assign push       = sel & {NUM_OUT{din_ready}};
    assign dout_valid = ~empty;
    assign pop        = dout_valid & dout_ready;
    assign addr_err   = addr_err_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            addr_err_q <= 1'b0;
        end else begin
            addr_err_q <= addr_err_d;
        end
    end

    for (genvar i = 0; i < NUM_OUT; i++) begin : g_ch
        logic [DATA_WIDTH-1:0] head;

        router_fifo #(
            .DATA_WIDTH(DATA_WIDTH),
            .DEPTH     (DEPTH)
        ) u_fifo (
            .clk    (clk),
            .reset  (reset),
            .push_i (push[i]),
            .pop_i  (pop[i]),
            .din_i  (din),
            .full_o (full[i]),
            .empty_o(empty[i]),
            .head_o (head)
        );

        // Never present stale data on an idle channel.
        assign dout[i*DATA_WIDTH +: DATA_WIDTH] = empty[i] ? '0 : head;

        a_dout_zero: assert property (@(posedge clk) disable iff (reset)
            !dout_valid[i] |-> (dout[i*DATA_WIDTH +: DATA_WIDTH] == '0));
    end

    a_push_onehot: assert property (@(posedge clk) disable iff (reset)
        (din_valid && !din_bcast) |-> $onehot0(push));
    a_no_push_full: assert property (@(posedge clk) disable iff (reset)
        (push & full) == '0);

endmodule
